// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between the write requesters, the FIFO write port and fifo_wr_arb.
// The master side drives requests and FIFO status; the slave side is the arbiter.
interface fifo_wr_arb_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NREQ  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_write_en;
    logic [WIDTH-1:0]      fifo_datain;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (
        output req, din, fifo_full, fifo_count,
        input  ack, fifo_write_en, fifo_datain, owner, busy
    );

    modport slave (
        input  req, din, fifo_full, fifo_count,
        output ack, fifo_write_en, fifo_datain, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding NREQ requesters into one FIFO write port.
// Each grant lasts up to BURST accepted beats; writes are registered one cycle after acceptance.
module fifo_wr_arb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input logic          clk,
    input logic          reset,
    fifo_wr_arb_if.slave bus
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int OW  = $clog2(NREQ);
    localparam int BW  = $clog2(BURST + 1);
    localparam int NM1 = NREQ - 1;
    localparam int BM1 = BURST - 1;
    localparam logic [CW:0]   DEPTH_V = DEPTH[CW:0];
    localparam logic [OW-1:0] OWN_MAX = NM1[OW-1:0];
    localparam logic [BW-1:0] LAST_V  = BM1[BW-1:0];

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                     state, state_nx;
    logic [OW-1:0]              rr_ptr, owner, pick, cand, owner_inc;
    logic [BW-1:0]              beat_cnt;
    logic [NREQ-1:0][WIDTH-1:0] din_a;
    logic [CW:0]                occ;
    logic                       space, xfer, last_beat, busy;

    assign din_a = bus.din;

    // fifo_count lags our own registered write by a cycle, so count it in.
    assign occ       = {1'b0, bus.fifo_count} + {{CW{1'b0}}, bus.fifo_write_en};
    assign space     = (occ < DEPTH_V) && !bus.fifo_full;
    assign xfer      = busy && bus.req[owner] && space;
    assign last_beat = (beat_cnt == LAST_V);
    assign owner_inc = (owner == OWN_MAX) ? '0 : owner + OW'(1);

    // First requester at or above rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        pick = rr_ptr;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = OW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (|bus.req) state_nx = S_BURST;
            S_BURST: begin
                if (!bus.req[owner])        state_nx = S_IDLE;
                else if (xfer && last_beat) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == S_BURST);
        bus.ack = '0;
        if (busy) bus.ack[owner] = space;
    end

    assign bus.busy  = busy;
    assign bus.owner = owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= '0;
            owner             <= '0;
            beat_cnt          <= '0;
            bus.fifo_write_en <= 1'b0;
            bus.fifo_datain   <= '0;
        end else begin
            bus.fifo_write_en <= xfer;
            if (xfer) bus.fifo_datain <= din_a[owner];
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    // Stalls (no space) leave beat_cnt and ownership untouched.
                    if (!bus.req[owner]) begin
                        rr_ptr <= owner_inc;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (last_beat) rr_ptr <= owner_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed vector table, hand-written corner sequences and a random scoreboard run
// against a queue model of the downstream FIFO.
module tb_fifo_wr_arb;
    localparam int W = 8;
    localparam int D = 16;
    localparam int N = 4;
    localparam int B = 4;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fifo_wr_arb_if #(.WIDTH(W), .DEPTH(D), .NREQ(N)) bus ();

    fifo_wr_arb #(.WIDTH(W), .DEPTH(D), .NREQ(N), .BURST(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       use_force = 1'b1;
    logic [4:0] cnt_force = '0;
    logic       full_force = 1'b0;
    logic [4:0] model_cnt = '0;
    logic       rd = 1'b0;
    logic       sb_on = 1'b0;

    always_comb begin
        bus.fifo_count = use_force ? cnt_force : model_cnt;
        bus.fifo_full  = use_force ? full_force : (model_cnt == 5'(D));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: compare outputs at the falling edge, then move to just past the next rising edge.
    task automatic cyc(input string nm, input logic [3:0] e_ack, input logic e_busy,
                       input logic [1:0] e_own, input logic e_we, input logic [7:0] e_dat);
        @(negedge clk);
        chk({nm, " ack"},   32'(bus.ack), 32'(e_ack));
        chk({nm, " busy"},  32'(bus.busy), 32'(e_busy));
        chk({nm, " owner"}, 32'(bus.owner), 32'(e_own));
        chk({nm, " we"},    32'(bus.fifo_write_en), 32'(e_we));
        chk({nm, " data"},  32'(bus.fifo_datain), 32'(e_dat));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // FIFO model and scoreboard for the random phase.
    logic [W-1:0] mem_q[$];
    logic [W-1:0] acc_q[$];
    int           wait_b[N];
    logic         busy_q = 1'b0;
    int           nwrites = 0;

    always @(posedge clk) begin
        if (sb_on) begin
            if (bus.fifo_write_en) begin
                nwrites++;
                chk("overflow", 32'(mem_q.size() < D), 32'd1);
                if (acc_q.size() == 0) chk("order underrun", 32'(bus.fifo_datain), 32'hffff_ffff);
                else                   chk("order", 32'(bus.fifo_datain), 32'(acc_q.pop_front()));
            end
            if (rd && mem_q.size() > 0) void'(mem_q.pop_front());
            if (bus.fifo_write_en) mem_q.push_back(bus.fifo_datain);
            model_cnt <= 5'(mem_q.size());
            for (int i = 0; i < N; i++)
                if (bus.req[i] && bus.ack[i]) acc_q.push_back(bus.din[i*W +: W]);
            if (bus.busy && !busy_q) begin
                chk("starvation", 32'(wait_b[bus.owner] <= N), 32'd1);
                for (int j = 0; j < N; j++) begin
                    if (j == int'(bus.owner)) wait_b[j] = 0;
                    else if (bus.req[j])      wait_b[j]++;
                    else                      wait_b[j] = 0;
                end
            end
            busy_q = bus.busy;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [4:0]  cnt;
        logic        full;
        logic [3:0]  ack;
        logic        busy;
        logic [1:0]  own;
        logic        we;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [3:0] xf;

        tbl[0]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[1]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h00};
        tbl[2]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[3]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[4]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[5]  = '{4'b0001, 32'h0000_0020, 5'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h20};
        tbl[6]  = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h20};
        tbl[7]  = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[8]  = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[9]  = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h20};
        tbl[10] = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h20};
        tbl[11] = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h20};
        tbl[12] = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'h22};
        tbl[13] = '{4'b1111, 32'h4433_2220, 5'd0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 8'h22};
        tbl[14] = '{4'b1111, 32'h4433_2220, 5'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h22};

        // Reset state, with requests already asserted so ack=0 means something.
        reset   = 1'b1;
        bus.req = 4'b1111;
        bus.din = 32'hdead_beef;
        #1 reset = 1'b0;
        #2;
        chk("reset ack",   32'(bus.ack), 32'd0);
        chk("reset busy",  32'(bus.busy), 32'd0);
        chk("reset owner", 32'(bus.owner), 32'd0);
        chk("reset we",    32'(bus.fifo_write_en), 32'd0);
        chk("reset data",  32'(bus.fifo_datain), 32'd0);

        bus.req = '0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.req    = tbl[i].req;
            bus.din    = tbl[i].din;
            cnt_force  = tbl[i].cnt;
            full_force = tbl[i].full;
            cyc($sformatf("row%0d", i), tbl[i].ack, tbl[i].busy, tbl[i].own, tbl[i].we, tbl[i].dat);
        end

        // Round robin with every requester active: owners 0,1,2,3,0, one idle cycle between.
        bus.req = '0; full_force = 1'b0; cnt_force = '0;
        do_reset();
        bus.req = 4'b1111;
        bus.din = 32'h4433_2211;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            chk($sformatf("rr%0d gap busy", b), 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
            for (int t = 0; t < B; t++) begin
                @(negedge clk);
                chk($sformatf("rr%0d.%0d owner", b, t), 32'(bus.owner), 32'(b % N));
                chk($sformatf("rr%0d.%0d ack", b, t), 32'(bus.ack), 32'(1 << (b % N)));
                @(posedge clk);
                #1;
            end
        end

        // Full stall: one write at count 15, hold through full, resume keeping beat count.
        bus.req = '0;
        do_reset();
        bus.req = 4'b0001; bus.din = 32'h0000_005a; cnt_force = 5'd15; full_force = 1'b0;
        cyc("st0", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        cyc("st1", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h00);
        cyc("st2", 4'b0000, 1'b1, 2'd0, 1'b1, 8'h5a);
        cnt_force = 5'd16; full_force = 1'b1;
        cyc("st3", 4'b0000, 1'b1, 2'd0, 1'b0, 8'h5a);
        cyc("st4", 4'b0000, 1'b1, 2'd0, 1'b0, 8'h5a);
        cnt_force = 5'd14; full_force = 1'b0;
        cyc("st5", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h5a);
        cnt_force = 5'd0;
        cyc("st6", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h5a);
        cyc("st7", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h5a);
        cyc("st8", 4'b0000, 1'b0, 2'd0, 1'b1, 8'h5a);

        // Early release by owner 2 after two beats; next search starts at 3.
        bus.req = '0;
        do_reset();
        bus.req = 4'b0100; bus.din = 32'h0077_0000;
        cyc("er0", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        cyc("er1", 4'b0100, 1'b1, 2'd2, 1'b0, 8'h00);
        cyc("er2", 4'b0100, 1'b1, 2'd2, 1'b1, 8'h77);
        bus.req = 4'b0000;
        cyc("er3", 4'b0100, 1'b1, 2'd2, 1'b1, 8'h77);
        bus.req = 4'b1111;
        cyc("er4", 4'b0000, 1'b0, 2'd2, 1'b0, 8'h77);
        cyc("er5", 4'b1000, 1'b1, 2'd3, 1'b0, 8'h77);

        // Reset in the middle of a burst drops the pending write at once.
        bus.req = '0;
        do_reset();
        bus.req = 4'b1111; bus.din = 32'h4433_2211;
        cyc("rm0", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        cyc("rm1", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h00);
        cyc("rm2", 4'b0001, 1'b1, 2'd0, 1'b1, 8'h11);
        reset = 1'b0;
        #1;
        chk("rm async we",   32'(bus.fifo_write_en), 32'd0);
        chk("rm async busy", 32'(bus.busy), 32'd0);
        chk("rm async ack",  32'(bus.ack), 32'd0);
        #9;
        reset   = 1'b1;
        bus.req = 4'b0110;
        cyc("rm3", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        cyc("rm4", 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00);

        // Random requesters against a randomly drained FIFO model.
        bus.req = '0;
        do_reset();
        mem_q.delete();
        acc_q.delete();
        for (int i = 0; i < N; i++) wait_b[i] = 0;
        use_force = 1'b0;
        sb_on     = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            xf = bus.req & bus.ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (xf[i]) begin
                        bus.din[i*W +: W] = 8'($urandom);
                        if ($urandom_range(3) == 0) bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.din[i*W +: W] = 8'($urandom);
                end
            end
            rd = 1'($urandom_range(1));
        end
        @(negedge clk);
        sb_on = 1'b0;
        chk("random writes seen", 32'(nwrites > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
